// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter with IDLE/BUSY/DONE sequencing.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_rd_en_i,
  input  logic                  m0_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_rd_en_i,
  input  logic                  m1_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  mem_rd_en_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [DATA_WIDTH-1:0] m0_data_q, m0_data_d;
  logic [DATA_WIDTH-1:0] m1_data_q, m1_data_d;
  logic                  m0_ack_q, m0_ack_d;
  logic                  m1_ack_q, m1_ack_d;
  logic                  req0, req1, pick, pick_wr;
  logic                  tmo_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             m0_err_q, m0_err_d;
  logic             m1_err_q, m1_err_d;

  // Fires at the end of the TIMEOUT_CYCLES-th BUSY cycle; a same-cycle ack wins.
  assign tmo_hit = (state_q == BUSY) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = '0;
    m0_err_d  = 1'b0;
    m1_err_d  = 1'b0;
    if (state_q == BUSY && state_d == BUSY) tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    if (tmo_hit && !mem_ack_i) begin
      m0_err_d = ~grant_q;
      m1_err_d = grant_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      m0_err_q  <= 1'b0;
      m1_err_q  <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      m0_err_q  <= m0_err_d;
      m1_err_q  <= m1_err_d;
    end
  end

  assign m0_err_o = m0_err_q;
  assign m1_err_o = m1_err_q;
`else
  assign tmo_hit  = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  assign req0    = m0_rd_en_i | m0_wr_en_i;
  assign req1    = m1_rd_en_i | m1_wr_en_i;
  // Contention goes to whoever was not granted last; a lone requester always wins.
  assign pick    = (req0 && req1) ? ~last_grant_q : req1;
  assign pick_wr = pick ? m1_wr_en_i : m0_wr_en_i;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_rd_en_d  = mem_rd_en_q;
    mem_wr_en_d  = mem_wr_en_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    m0_data_d    = m0_data_q;
    m1_data_d    = m1_data_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d      = BUSY;
          grant_d      = pick;
          last_grant_d = pick;
          mem_wr_en_d  = pick_wr;
          mem_rd_en_d  = ~pick_wr;
          mem_addr_d   = pick ? m1_addr_i : m0_addr_i;
          mem_data_d   = pick ? m1_data_i : m0_data_i;
        end
      end
      BUSY: begin
        if (mem_ack_i || tmo_hit) begin
          state_d     = DONE;
          mem_rd_en_d = 1'b0;
          mem_wr_en_d = 1'b0;
          m0_ack_d    = ~grant_q;
          m1_ack_d    = grant_q;
          if (mem_ack_i && mem_rd_en_q) begin
            if (grant_q) m1_data_d = mem_data_i;
            else         m0_data_d = mem_data_i;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      m0_data_q    <= '0;
      m1_data_q    <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      m0_data_q    <= m0_data_d;
      m1_data_q    <= m1_data_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
    end
  end

  assign m0_data_o   = m0_data_q;
  assign m1_data_o   = m1_data_q;
  assign m0_ack_o    = m0_ack_q;
  assign m1_ack_o    = m1_ack_q;
  assign mem_rd_en_o = mem_rd_en_q;
  assign mem_wr_en_o = mem_wr_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;

endmodule
